// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory port between an instruction cache and a
//               data cache. The grant is combinational; a lock keeps the bus
//               with a requester until memory accepts its request. An owner
//               table routes returned load tags back to the issuing cache.
//               Compile-time macro MEM_ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration; without it dcache has fixed priority and a
//               starvation counter force-grants icache after STARVE_LIMIT
//               consecutive denied cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache_command,
  input  logic [63:0] icache_addr,
  input  logic [1:0]  dcache_command,
  input  logic [63:0] dcache_addr,
  input  logic [63:0] dcache_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  mem2icache_response,
  output logic [3:0]  mem2icache_tag,
  output logic [63:0] mem2icache_data,
  output logic [3:0]  mem2dcache_response,
  output logic [3:0]  mem2dcache_tag,
  output logic [63:0] mem2dcache_data,
  output logic [3:0]  icache_outstanding,
  output logic [3:0]  dcache_outstanding
);

  localparam logic [1:0] c_BUS_NONE = 2'd0;
  localparam logic [1:0] c_BUS_LOAD = 2'd1;
  localparam logic [3:0] c_CNT_MAX  = 4'hF;

  typedef enum logic [1:0] {
    LOCK_NONE   = 2'd0,
    LOCK_ICACHE = 2'd1,
    LOCK_DCACHE = 2'd2
  } lock_t;

  lock_t       r_lock;
  lock_t       w_lock_next;
  logic [15:0] r_valid;
  logic [15:0] r_owner_d;     // 1 = entry owned by dcache
  logic [3:0]  r_i_out;
  logic [3:0]  r_d_out;

  logic        w_i_req;
  logic        w_d_req;
  logic        w_grant_i;
  logic        w_grant_d;
  logic [1:0]  w_cmd;
  logic        w_accept;
  logic        w_accept_load;
  logic        w_ret_hit;
  logic        w_ret_owner_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_favor_d;            // 1 = dcache wins the next unlocked contest
`else
  localparam int c_STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [c_STARVE_W-1:0] r_starve;
`endif

  // An icache store is not a legal request and is ignored outright.
  assign w_i_req = (icache_command == c_BUS_LOAD);
  assign w_d_req = (dcache_command != c_BUS_NONE);

  // Grant selection: locked owner only, otherwise the configured policy.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_lock)
      LOCK_ICACHE: w_grant_i = w_i_req;
      LOCK_DCACHE: w_grant_d = w_d_req;
      default: begin
        if (w_i_req && w_d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (r_favor_d) w_grant_d = 1'b1;
          else           w_grant_i = 1'b1;
`else
          if (r_starve >= c_STARVE_W'(STARVE_LIMIT)) w_grant_i = 1'b1;
          else                                       w_grant_d = 1'b1;
`endif
        end else begin
          w_grant_i = w_i_req;
          w_grant_d = w_d_req;
        end
      end
    endcase
  end

  // Memory port mux and response/tag routing.
  always_comb begin
    w_cmd         = c_BUS_NONE;
    proc2mem_addr = 64'd0;
    proc2mem_data = 64'd0;
    if (w_grant_i) begin
      w_cmd         = c_BUS_LOAD;
      proc2mem_addr = icache_addr;
    end else if (w_grant_d) begin
      w_cmd         = dcache_command;
      proc2mem_addr = dcache_addr;
      proc2mem_data = dcache_data;
    end
    w_accept      = (w_grant_i || w_grant_d) && (mem2proc_response != 4'd0);
    w_accept_load = w_accept && (w_cmd == c_BUS_LOAD);

    mem2icache_response = w_grant_i ? mem2proc_response : 4'd0;
    mem2dcache_response = w_grant_d ? mem2proc_response : 4'd0;

    // Tag 0 means "nothing returned"; unknown tags are silently dropped.
    w_ret_hit      = (mem2proc_tag != 4'd0) && r_valid[mem2proc_tag];
    w_ret_owner_d  = r_owner_d[mem2proc_tag];
    mem2icache_tag = (w_ret_hit && !w_ret_owner_d) ? mem2proc_tag : 4'd0;
    mem2dcache_tag = (w_ret_hit &&  w_ret_owner_d) ? mem2proc_tag : 4'd0;
  end

  assign proc2mem_command   = w_cmd;
  assign mem2icache_data    = mem2proc_data;
  assign mem2dcache_data    = mem2proc_data;
  assign icache_outstanding = r_i_out;
  assign dcache_outstanding = r_d_out;

  // Lock next-state: hold the bus for a requester that memory has not yet accepted.
  always_comb begin
    w_lock_next = r_lock;
    case (r_lock)
      LOCK_NONE: begin
        if (w_grant_i && (mem2proc_response == 4'd0))      w_lock_next = LOCK_ICACHE;
        else if (w_grant_d && (mem2proc_response == 4'd0)) w_lock_next = LOCK_DCACHE;
      end
      LOCK_ICACHE: if (!w_i_req || (mem2proc_response != 4'd0)) w_lock_next = LOCK_NONE;
      LOCK_DCACHE: if (!w_d_req || (mem2proc_response != 4'd0)) w_lock_next = LOCK_NONE;
      default:     w_lock_next = LOCK_NONE;
    endcase
  end

  // Lock state register.
  always_ff @(posedge clock) begin
    if (reset) r_lock <= LOCK_NONE;
    else       r_lock <= w_lock_next;
  end

  // Owner table: free on return, then record new loads so a same-cycle re-issue wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid   <= 16'd0;
      r_owner_d <= 16'd0;
    end else begin
      if (w_ret_hit) r_valid[mem2proc_tag] <= 1'b0;
      if (w_accept_load) begin
        r_valid[mem2proc_response]   <= 1'b1;
        r_owner_d[mem2proc_response] <= w_grant_d;
      end
    end
  end

  // Saturating in-flight load counters per cache.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_out <= 4'd0;
      r_d_out <= 4'd0;
    end else begin
      if ((w_accept_load && w_grant_i) && !(w_ret_hit && !w_ret_owner_d)) begin
        if (r_i_out != c_CNT_MAX) r_i_out <= r_i_out + 4'd1;
      end else if (!(w_accept_load && w_grant_i) && (w_ret_hit && !w_ret_owner_d)) begin
        if (r_i_out != 4'd0) r_i_out <= r_i_out - 4'd1;
      end
      if ((w_accept_load && w_grant_d) && !(w_ret_hit && w_ret_owner_d)) begin
        if (r_d_out != c_CNT_MAX) r_d_out <= r_d_out + 4'd1;
      end else if (!(w_accept_load && w_grant_d) && (w_ret_hit && w_ret_owner_d)) begin
        if (r_d_out != 4'd0) r_d_out <= r_d_out - 4'd1;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer: after each accepted transfer favour the other cache.
  always_ff @(posedge clock) begin
    if (reset)         r_favor_d <= 1'b1;
    else if (w_accept) r_favor_d <= w_grant_i;
  end
`else
  // Starvation counter: consecutive cycles icache requests but is not granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_grant_i && (mem2proc_response != 4'd0)) begin
      r_starve <= '0;
    end else if (!w_i_req) begin
      r_starve <= '0;
    end else if (!w_grant_i && (r_starve < c_STARVE_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + c_STARVE_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Expected tag routing
//               is queued when a request is accepted and compared when the
//               tag comes back. Honours MEM_ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int          STARVE_LIMIT = 8;
  localparam logic [1:0]  c_NONE  = 2'd0;
  localparam logic [1:0]  c_LOAD  = 2'd1;
  localparam logic [1:0]  c_STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache_command;
  logic [63:0] icache_addr;
  logic [1:0]  dcache_command;
  logic [63:0] dcache_addr;
  logic [63:0] dcache_data;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2icache_response;
  logic [3:0]  mem2icache_tag;
  logic [63:0] mem2icache_data;
  logic [3:0]  mem2dcache_response;
  logic [3:0]  mem2dcache_tag;
  logic [63:0] mem2dcache_data;
  logic [3:0]  icache_outstanding;
  logic [3:0]  dcache_outstanding;

  mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock               (clock),
    .reset               (reset),
    .icache_command      (icache_command),
    .icache_addr         (icache_addr),
    .dcache_command      (dcache_command),
    .dcache_addr         (dcache_addr),
    .dcache_data         (dcache_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_tag        (mem2proc_tag),
    .mem2proc_data       (mem2proc_data),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .proc2mem_data       (proc2mem_data),
    .mem2icache_response (mem2icache_response),
    .mem2icache_tag      (mem2icache_tag),
    .mem2icache_data     (mem2icache_data),
    .mem2dcache_response (mem2dcache_response),
    .mem2dcache_tag      (mem2dcache_tag),
    .mem2dcache_data     (mem2dcache_data),
    .icache_outstanding  (icache_outstanding),
    .dcache_outstanding  (dcache_outstanding)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] tag;
    logic [3:0] exp_itag;
    logic [3:0] exp_dtag;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       checks = 0;
  int       errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] icmd, input logic [63:0] iaddr,
                       input logic [1:0] dcmd, input logic [63:0] daddr,
                       input logic [63:0] ddata, input logic [3:0] resp,
                       input logic [3:0] tag);
    icache_command    = icmd;
    icache_addr       = iaddr;
    dcache_command    = dcmd;
    dcache_addr       = daddr;
    dcache_data       = ddata;
    mem2proc_response = resp;
    mem2proc_tag      = tag;
    #1;
  endtask

  task automatic idle();
    drive(c_NONE, 64'd0, c_NONE, 64'd0, 64'd0, 4'd0, 4'd0);
  endtask

  // Return the oldest queued tag from memory and compare its routing.
  task automatic ret_next(input string name);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      it = sb_q.pop_front();
      mem2proc_data = 64'hDA7A_0000_0000_0000 | 64'(it.tag);
      drive(c_NONE, 64'd0, c_NONE, 64'd0, 64'd0, 4'd0, it.tag);
      check({name, "_itag"},  64'(mem2icache_tag), 64'(it.exp_itag));
      check({name, "_dtag"},  64'(mem2dcache_tag), 64'(it.exp_dtag));
      check({name, "_idata"}, mem2icache_data, 64'hDA7A_0000_0000_0000 | 64'(it.tag));
      check({name, "_ddata"}, mem2dcache_data, 64'hDA7A_0000_0000_0000 | 64'(it.tag));
    end
    tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Main stimulus sequence.
  initial begin
    logic        exp_d;
    int          exp_i_cnt;
    int          exp_d_cnt;

    reset = 1'b1;
    mem2proc_data = 64'd0;
    idle();
    tick();
    tick();
    check("rst_cmd",   64'(proc2mem_command), 64'(c_NONE));
    check("rst_iresp", 64'(mem2icache_response), 64'd0);
    check("rst_dresp", 64'(mem2dcache_response), 64'd0);
    check("rst_iout",  64'(icache_outstanding), 64'd0);
    check("rst_dout",  64'(dcache_outstanding), 64'd0);
    reset = 1'b0;

    // icache load alone, accepted with tag 3
    drive(c_LOAD, 64'h1000, c_NONE, 64'd0, 64'd0, 4'd3, 4'd0);
    check("t1_cmd",   64'(proc2mem_command), 64'(c_LOAD));
    check("t1_addr",  proc2mem_addr, 64'h1000);
    check("t1_data",  proc2mem_data, 64'd0);
    check("t1_iresp", 64'(mem2icache_response), 64'd3);
    check("t1_dresp", 64'(mem2dcache_response), 64'd0);
    sb_q.push_back('{4'd3, 4'd3, 4'd0});
    tick();
    idle();
    check("t1_iout1", 64'(icache_outstanding), 64'd1);
    ret_next("t1_ret");
    idle();
    check("t1_iout0", 64'(icache_outstanding), 64'd0);

    // dcache store accepted with tag 5: not recorded, its tag is dropped
    drive(c_NONE, 64'd0, c_STORE, 64'h2000, 64'hAB, 4'd5, 4'd0);
    check("t2_cmd",   64'(proc2mem_command), 64'(c_STORE));
    check("t2_addr",  proc2mem_addr, 64'h2000);
    check("t2_data",  proc2mem_data, 64'hAB);
    check("t2_dresp", 64'(mem2dcache_response), 64'd5);
    check("t2_iresp", 64'(mem2icache_response), 64'd0);
    sb_q.push_back('{4'd5, 4'd0, 4'd0});
    tick();
    idle();
    check("t2_dout", 64'(dcache_outstanding), 64'd0);
    ret_next("t2_ret");

    // dcache load waits 3 cycles, icache joins, lock holds until tag 7
    for (int k = 0; k < 3; k++) begin
      drive(c_NONE, 64'd0, c_LOAD, 64'h3000, 64'd0, 4'd0, 4'd0);
      check("t3_wait_addr", proc2mem_addr, 64'h3000);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(c_LOAD, 64'h4000, c_LOAD, 64'h3000, 64'd0, 4'd0, 4'd0);
      check("t3_lock_addr",  proc2mem_addr, 64'h3000);
      check("t3_lock_iresp", 64'(mem2icache_response), 64'd0);
      tick();
    end
    drive(c_LOAD, 64'h4000, c_LOAD, 64'h3000, 64'd0, 4'd7, 4'd0);
    check("t3_acc_addr",  proc2mem_addr, 64'h3000);
    check("t3_acc_dresp", 64'(mem2dcache_response), 64'd7);
    check("t3_acc_iresp", 64'(mem2icache_response), 64'd0);
    sb_q.push_back('{4'd7, 4'd0, 4'd7});
    tick();
    idle();
    check("t3_dout1", 64'(dcache_outstanding), 64'd1);
    ret_next("t3_ret");
    idle();
    check("t3_dout0", 64'(dcache_outstanding), 64'd0);

    // both caches load every cycle, each accepted with a fresh tag
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      drive(c_LOAD, 64'h5000, c_LOAD, 64'h6000, 64'd0, 4'(k + 1), 4'd0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = ((k % 2) == 0);
`else
      exp_d = (k < STARVE_LIMIT);
`endif
      check("t4_addr",  proc2mem_addr, exp_d ? 64'h6000 : 64'h5000);
      check("t4_iresp", 64'(mem2icache_response), exp_d ? 64'd0 : 64'(k + 1));
      check("t4_dresp", 64'(mem2dcache_response), exp_d ? 64'(k + 1) : 64'd0);
      sb_q.push_back('{4'(k + 1), exp_d ? 4'd0 : 4'(k + 1), exp_d ? 4'(k + 1) : 4'd0});
      if (exp_d) exp_d_cnt++;
      else       exp_i_cnt++;
      tick();
    end
    idle();
    check("t4_iout", 64'(icache_outstanding), 64'(exp_i_cnt));
    check("t4_dout", 64'(dcache_outstanding), 64'(exp_d_cnt));
    for (int k = 0; k < 9; k++) ret_next("t4_ret");
    idle();
    check("t4_iout0", 64'(icache_outstanding), 64'd0);
    check("t4_dout0", 64'(dcache_outstanding), 64'd0);

    // tag 4 freed by icache and re-issued to dcache in the same cycle
    drive(c_LOAD, 64'h7000, c_NONE, 64'd0, 64'd0, 4'd4, 4'd0);
    sb_q.push_back('{4'd4, 4'd4, 4'd0});
    tick();
    begin
      sb_item_t it;
      if (sb_q.size() == 0) begin
        check("t5_sb_empty", 64'd0, 64'd1);
      end else begin
        it = sb_q.pop_front();
        drive(c_NONE, 64'd0, c_LOAD, 64'h8000, 64'd0, 4'd4, it.tag);
        check("t5_itag",  64'(mem2icache_tag), 64'(it.exp_itag));
        check("t5_dtag",  64'(mem2dcache_tag), 64'(it.exp_dtag));
        check("t5_dresp", 64'(mem2dcache_response), 64'd4);
      end
    end
    sb_q.push_back('{4'd4, 4'd0, 4'd4});
    tick();
    idle();
    check("t5_iout", 64'(icache_outstanding), 64'd0);
    check("t5_dout", 64'(dcache_outstanding), 64'd1);
    ret_next("t5_ret");
    idle();
    check("t5_dout0", 64'(dcache_outstanding), 64'd0);

    // three loads in flight, then reset discards them all
    drive(c_LOAD, 64'h9000, c_NONE, 64'd0, 64'd0, 4'd1, 4'd0);
    tick();
    drive(c_NONE, 64'd0, c_LOAD, 64'hA000, 64'd0, 4'd2, 4'd0);
    tick();
    drive(c_NONE, 64'd0, c_LOAD, 64'hB000, 64'd0, 4'd3, 4'd0);
    tick();
    idle();
    check("t6_iout_pre", 64'(icache_outstanding), 64'd1);
    check("t6_dout_pre", 64'(dcache_outstanding), 64'd2);
    reset = 1'b1;
    idle();
    check("t6_rst_cmd",   64'(proc2mem_command), 64'(c_NONE));
    check("t6_rst_iresp", 64'(mem2icache_response), 64'd0);
    check("t6_rst_dresp", 64'(mem2dcache_response), 64'd0);
    tick();
    reset = 1'b0;
    sb_q.delete();
    sb_q.push_back('{4'd2, 4'd0, 4'd0});
    ret_next("t6_ret");
    idle();
    check("t6_iout", 64'(icache_outstanding), 64'd0);
    check("t6_dout", 64'(dcache_outstanding), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8: the number of consecutive denied icache request cycles after which icache is force-granted (fixed-priority mode only).
REQ-002 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port icache_command, input, 2 bits: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; a BUS_STORE from icache is treated as BUS_NONE.
REQ-005 The block SHALL have port icache_addr, input, 64 bits: icache request address.
REQ-006 The block SHALL have ports dcache_command (input, 2 bits), dcache_addr (input, 64 bits) and dcache_data (input, 64 bits): the dcache request.
REQ-007 The block SHALL have ports mem2proc_response, mem2proc_tag (inputs, 4 bits each) and mem2proc_data (input, 64 bits): memory acceptance tag (0 = not accepted), completed load tag (0 = none), and load data.
REQ-008 The block SHALL have ports proc2mem_command (output, 2 bits), proc2mem_addr (output, 64 bits) and proc2mem_data (output, 64 bits): the single memory port.
REQ-009 The block SHALL have ports mem2icache_response, mem2icache_tag (outputs, 4 bits each) and mem2icache_data (output, 64 bits).
REQ-010 The block SHALL have ports mem2dcache_response, mem2dcache_tag (outputs, 4 bits each) and mem2dcache_data (output, 64 bits).
REQ-011 The block SHALL have ports icache_outstanding and dcache_outstanding, outputs, 4 bits each: in-flight load counts.

Function
REQ-012 The grant SHALL be combinational: the granted requester's command, address and data (data 0 for icache) drive proc2mem_*; with no grant, proc2mem_command=BUS_NONE and addr/data=0.
REQ-013 The granted requester's response output SHALL equal mem2proc_response; the other requester's response output SHALL be 0.
REQ-014 A lock register (NONE/ICACHE/DCACHE) SHALL be set to the granted requester when its command is non-NONE and mem2proc_response==0; while locked, only that requester is granted.
REQ-015 The lock SHALL clear when the locked request is accepted (response!=0) or the locked requester drives BUS_NONE.
REQ-016 When unlocked with both requesting, arbitration SHALL follow REQ-029/REQ-030.
REQ-017 On an accepted BUS_LOAD, owner_table[response] SHALL record the owner and be marked valid at the next edge; accepted stores SHALL NOT be recorded.
REQ-018 On mem2proc_tag!=0 with a valid entry, the owner's tag output SHALL equal mem2proc_tag, the other requester's tag output SHALL be 0, and the entry SHALL be invalidated at the next edge.
REQ-019 A returned tag with no valid entry SHALL be dropped: both tag outputs are 0 and there is no state change.
REQ-020 When the same tag number is freed (mem2proc_tag) and re-issued (mem2proc_response) in one cycle, the set SHALL win: the entry holds the new owner and remains valid.
REQ-021 mem2icache_data and mem2dcache_data SHALL both equal mem2proc_data unconditionally.
REQ-022 Each outstanding counter SHALL increment on its load acceptance and decrement on its tag return; a simultaneous increment and decrement leaves it unchanged; it saturates at 15 and does not go below 0.
REQ-023 Tag 0 SHALL never be recorded or routed.

Reset
REQ-024 When reset is asserted at a clock edge, the lock SHALL be set to NONE, all owner_table entries invalidated, both counters and the starvation counter cleared to 0, and the round-robin pointer set to favour dcache.
REQ-025 A reset mid-operation SHALL discard all in-flight ownership; tags returned after reset are dropped per REQ-019.
REQ-026 Combinational outputs SHALL follow inputs during reset: with no requests, proc2mem_command=BUS_NONE and all response and tag outputs are 0.

Configuration
REQ-027 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-028 The selection SHALL be made at compile time.
REQ-029 With MEM_ARB_ROUND_ROBIN_EN defined, the unlocked grant SHALL go to the requester not granted at the last accepted transfer, and the pointer SHALL update on each acceptance; STARVE_LIMIT is unused.
REQ-030 With MEM_ARB_ROUND_ROBIN_EN undefined, dcache SHALL have fixed priority; a starvation counter SHALL count consecutive cycles of icache request without grant and, when it reaches STARVE_LIMIT, force an icache grant and reset to 0 on icache acceptance.

Verification
REQ-031 The bench SHALL cover: icache LOAD 0x1000 alone, response=3 -> proc2mem_addr=0x1000, mem2icache_response=3; later tag=3 -> mem2icache_tag=3, mem2dcache_tag=0, icache_outstanding 1->0.
REQ-032 The bench SHALL cover: dcache STORE 0x2000 data 0xAB, response=5 -> mem2dcache_response=5, no table entry; later tag=5 -> both tag outputs are 0.
REQ-033 The bench SHALL cover: dcache LOAD with response=0 for 3 cycles, then icache requesting -> grant stays with dcache (lock) until response=7.
REQ-034 The bench SHALL cover: both loading continuously -> round-robin build alternates D,I,D,I; fixed build with STARVE_LIMIT=8 grants icache on the 9th cycle.
REQ-035 The bench SHALL cover: a cycle with tag=4 (icache-owned) and response=4 for a dcache load -> mem2icache_tag=4, and the entry becomes dcache-owned and valid.
REQ-036 The bench SHALL cover: reset with 3 loads in flight, then tag=2 -> both tag outputs are 0 and both counters are 0.
